rv_mem_port_arbiter: RTL and testbench
======================================

Name: rv_mem_port_arbiter

Overview:
- Parametrised successor to the single-port RV2T memory front end.
- Arbitrates OCD, instruction fetch and data load/store onto one external RAM port, with fixed priority and explicit grants.
- Supports configurable RAM read latency and tags each returned word with its source.
- Performs sub-word (byte/half) store lane steering and load extraction with sign extension, and flags misaligned data accesses.

Parameters:
XLEN, 32, data word width; legal values 32 or 64. OFF = log2(XLEN/8) byte-offset bits.
ADDR_BITS, 16, byte-address width of the data port; word address width is ADDR_BITS-OFF.
READ_LATENCY, 1, cycles from mem_read_enable sampled to mem_read_data valid; legal 1..4.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sync_reset  in  1  synchronous flush, active-high
ocd_read_enable  in  1  OCD word read request
ocd_write_enable  in  1  OCD full-word write request
ocd_rw_addr  in  ADDR_BITS-OFF  OCD word address
ocd_write_word  in  XLEN  OCD write data
code_read_enable  in  1  fetch request
code_read_addr  in  ADDR_BITS-OFF  fetch word address
data_read_enable  in  1  load request
data_write_enable  in  1  store request
data_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when XLEN=64)
data_unsigned  in  1  zero-extend load when 1
data_rw_addr  in  ADDR_BITS  data byte address
data_write_word  in  XLEN  store data, right-aligned
grant_ocd / grant_code / grant_data  out  1 each  combinational same-cycle grants
enable_out  out  1  returned word valid
source_out  out  2  0=OCD, 1=code, 2=data
word_out  out  XLEN  returned word (formatted for data source)
misaligned_err  out  1  one-cycle pulse
mem_addr  out  ADDR_BITS-OFF  RAM word address
mem_read_enable  out  1  RAM read strobe
mem_write_en  out  XLEN/8  RAM byte enables
mem_write_data  out  XLEN  RAM write data, lane-steered
mem_read_data  in  XLEN  RAM read data

Behaviour:
- Priority: OCD > code > data. Only one grant is high per cycle. A losing requester is not queued; it must hold its request until granted.
- Grants, mem_addr, mem_read_enable, mem_write_en and mem_write_data are combinational from the granted request.
- When no request is granted: mem_read_enable = 0, mem_write_en = 0, mem_addr = data word address.
- OCD write: mem_write_en all ones. If OCD read and write are both high, the write wins and no return is generated.
- Data store: byte enables are set by size and offset. Data is replicated across lanes (byte to every byte lane, half to every half lane).
- Data load and store both high: treated as a store, no return.
- Misalignment: half with addr[0]≠0, word with addr[OFF-2:0]≠0 (XLEN=64), dword with offset≠0, or size 3 when XLEN=32 is misaligned.
  - The data grant is still asserted and the request is consumed.
  - mem_read_enable and mem_write_en are 0 for that access.
  - misaligned_err pulses high on the next cycle. No enable_out is generated.
- Return pipeline: READ_LATENCY registered stages, each carrying {valid, source, offset, size, unsigned}.
  - Loaded with valid=1 on any cycle mem_read_enable=1.
  - enable_out and source_out come from the tail stage. word_out is combinational from mem_read_data and the tail tag.
  - Total latency equals READ_LATENCY; enable_out rises READ_LATENCY cycles after the grant.
  - Back-to-back reads are sustained at one per cycle.
- Formatting: OCD and code returns pass mem_read_data unchanged. Data returns shift right by offset*8, then sign- or zero-extend per size and unsigned.
- sync_reset: clears all pipeline valid bits and misaligned_err on the next edge, and forces mem_read_enable and mem_write_en to 0 in that cycle. Grants still follow priority.
- reset (async): pipeline valids 0, enable_out 0, source_out 0, misaligned_err 0.
  - word_out is don't-care while enable_out = 0.
  - In-flight reads are discarded; their returns are never reported.

Test Plan:
- XLEN=32, RL=1: code_read_enable and data_read_enable together at word 0x10 / byte 0x80 → grant_code only, mem_addr=0x10; next cycle enable_out=1, source_out=1. Data is granted the following cycle and returns with source_out=2.
- Store byte 0xA5 at addr 0x103 → mem_write_en=4'b1000, mem_write_data=0xA5A5A5A5. Subsequent signed byte load with mem_read_data=0xA5000000 → word_out=0xFFFFFFA5; unsigned load → 0x000000A5.
- Half load at addr 0x101 → mem_read_enable=0, misaligned_err=1 exactly one cycle later, no enable_out.
- RL=3: reads to word addresses 1,2,3 on consecutive cycles → enable_out high on cycles 3,4,5 with matching source tags and no bubbles.
- RL=2: issue a read, then assert reset one cycle later → enable_out stays 0. Issue a read, then assert sync_reset one cycle later → no return from that read.
- OCD write 0x12345678 while code and data also request → only grant_ocd=1, mem_write_en=4'hF, mem_write_data=0x12345678.

Source files
------------

// File: rtl/rv_mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: three requesters plus the RAM port.
// The arbiter takes the slave side; the requesters/RAM model take the master side.
interface rv_mem_port_arbiter_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 16
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int WA  = ADDR_BITS - OFF;

    logic            ocd_read_enable;
    logic            ocd_write_enable;
    logic [WA-1:0]   ocd_rw_addr;
    logic [XLEN-1:0] ocd_write_word;
    logic            code_read_enable;
    logic [WA-1:0]   code_read_addr;
    logic            data_read_enable;
    logic            data_write_enable;
    logic [1:0]      data_size;
    logic            data_unsigned;
    logic [ADDR_BITS-1:0] data_rw_addr;
    logic [XLEN-1:0] data_write_word;

    logic            grant_ocd;
    logic            grant_code;
    logic            grant_data;
    logic            enable_out;
    logic [1:0]      source_out;
    logic [XLEN-1:0] word_out;
    logic            misaligned_err;

    logic [WA-1:0]   mem_addr;
    logic            mem_read_enable;
    logic [NB-1:0]   mem_write_en;
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] mem_read_data;

    modport slave (
        input  ocd_read_enable, ocd_write_enable, ocd_rw_addr, ocd_write_word,
        input  code_read_enable, code_read_addr,
        input  data_read_enable, data_write_enable, data_size, data_unsigned,
        input  data_rw_addr, data_write_word, mem_read_data,
        output grant_ocd, grant_code, grant_data,
        output enable_out, source_out, word_out, misaligned_err,
        output mem_addr, mem_read_enable, mem_write_en, mem_write_data
    );

    modport master (
        output ocd_read_enable, ocd_write_enable, ocd_rw_addr, ocd_write_word,
        output code_read_enable, code_read_addr,
        output data_read_enable, data_write_enable, data_size, data_unsigned,
        output data_rw_addr, data_write_word, mem_read_data,
        input  grant_ocd, grant_code, grant_data,
        input  enable_out, source_out, word_out, misaligned_err,
        input  mem_addr, mem_read_enable, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/rv_mem_port_arbiter.sv
// Fixed-priority OCD > fetch > load/store arbiter onto one RAM port,
// with store lane steering, tagged read-return pipeline and load formatting.
module rv_mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_BITS    = 16,
    parameter int READ_LATENCY = 1
) (
    input logic clk,
    input logic reset,
    input logic sync_reset,
    rv_mem_port_arbiter_if.slave bus
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int WA  = ADDR_BITS - OFF;

    localparam logic [1:0] SRC_OCD  = 2'd0;
    localparam logic [1:0] SRC_CODE = 2'd1;
    localparam logic [1:0] SRC_DATA = 2'd2;

    typedef struct packed {
        logic           vld;
        logic [1:0]     src;
        logic [OFF-1:0] off;
        logic [1:0]     size;
        logic           uns;
    } tag_t;

    logic            w_ocd_req;
    logic            w_code_req;
    logic            w_data_req;
    logic            w_mis;
    logic [OFF-1:0]  w_off;
    logic [WA-1:0]   w_daddr;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_re;
    logic [1:0]      w_src;
    tag_t            w_tag_in;
    tag_t            w_tail;
    logic [XLEN-1:0] w_sh;

    tag_t            r_pipe [READ_LATENCY];
    logic            r_mis;

    assign w_ocd_req  = bus.ocd_read_enable | bus.ocd_write_enable;
    assign w_code_req = bus.code_read_enable;
    assign w_data_req = bus.data_read_enable | bus.data_write_enable;
    assign w_off      = bus.data_rw_addr[OFF-1:0];
    assign w_daddr    = bus.data_rw_addr[ADDR_BITS-1:OFF];

    assign bus.grant_ocd  = w_ocd_req;
    assign bus.grant_code = w_code_req & ~w_ocd_req;
    assign bus.grant_data = w_data_req & ~w_ocd_req & ~w_code_req;

    // Natural-alignment check and store lane steering for the data port.
    always_comb begin
        w_mis   = 1'b0;
        w_be    = '0;
        w_wdata = bus.data_write_word;
        unique case (bus.data_size)
            2'd0: begin
                w_be    = NB'(1) << w_off;
                w_wdata = {NB{bus.data_write_word[7:0]}};
            end
            2'd1: begin
                w_mis   = w_off[0];
                w_be    = NB'(3) << w_off;
                w_wdata = {(NB/2){bus.data_write_word[15:0]}};
            end
            2'd2: begin
                w_mis   = (w_off[1:0] != 2'b00);
                w_be    = NB'(4'hF) << w_off;
                w_wdata = {(XLEN/32){bus.data_write_word[31:0]}};
            end
            default: begin
                w_mis   = (XLEN == 32) ? 1'b1 : (w_off != '0);
                w_be    = '1;
                w_wdata = bus.data_write_word;
            end
        endcase
    end

    // RAM port mux driven by whichever requester holds the grant.
    always_comb begin
        bus.mem_addr       = w_daddr;
        bus.mem_write_data = w_wdata;
        bus.mem_write_en   = '0;
        w_re               = 1'b0;
        w_src              = SRC_DATA;
        if (w_ocd_req) begin
            bus.mem_addr       = bus.ocd_rw_addr;
            bus.mem_write_data = bus.ocd_write_word;
            w_src              = SRC_OCD;
            if (bus.ocd_write_enable) begin
                bus.mem_write_en = '1;
            end else begin
                w_re = 1'b1;
            end
        end else if (w_code_req) begin
            bus.mem_addr = bus.code_read_addr;
            w_src        = SRC_CODE;
            w_re         = 1'b1;
        end else if (w_data_req && !w_mis) begin
            if (bus.data_write_enable) begin
                bus.mem_write_en = w_be;
            end else begin
                w_re = 1'b1;
            end
        end
        if (sync_reset) begin
            w_re             = 1'b0;
            bus.mem_write_en = '0;
        end
    end

    assign bus.mem_read_enable = w_re;

    assign w_tag_in = '{vld:  w_re,
                        src:  w_src,
                        off:  w_off,
                        size: bus.data_size,
                        uns:  bus.data_unsigned};

    // Return tag pipeline and misalignment pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
            r_mis <= 1'b0;
        end else if (sync_reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i].vld <= 1'b0;
            end
            r_mis <= 1'b0;
        end else begin
            r_pipe[0] <= w_tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_mis <= bus.grant_data & w_mis;
        end
    end

    assign w_tail             = r_pipe[READ_LATENCY-1];
    assign bus.enable_out     = w_tail.vld;
    assign bus.source_out     = w_tail.src;
    assign bus.misaligned_err = r_mis;
    assign w_sh = bus.mem_read_data >> {w_tail.off, 3'b000};

    // Load formatting: shift the addressed bytes down, then extend.
    always_comb begin
        bus.word_out = bus.mem_read_data;
        if (w_tail.src == SRC_DATA) begin
            unique case (w_tail.size)
                2'd0: bus.word_out = w_tail.uns ? XLEN'(w_sh[7:0])
                                                : XLEN'($signed(w_sh[7:0]));
                2'd1: bus.word_out = w_tail.uns ? XLEN'(w_sh[15:0])
                                                : XLEN'($signed(w_sh[15:0]));
                2'd2: bus.word_out = w_tail.uns ? XLEN'(w_sh[31:0])
                                                : XLEN'($signed(w_sh[31:0]));
                default: bus.word_out = w_sh;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_mem_port_arbiter.sv
// Bench for rv_mem_port_arbiter: two instances (read latency 1 and 3)
// driven in lock-step, checked against a cycle-indexed return schedule.
module tb_rv_mem_port_arbiter;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, srst;
    logic        ocd_re, ocd_we, code_re, dre, dwe, duns;
    logic [13:0] ocd_addr, code_addr;
    logic [31:0] ocd_wd, dwd, rdata;
    logic [1:0]  dsize;
    logic [15:0] daddr;

    rv_mem_port_arbiter_if #(.XLEN(32), .ADDR_BITS(16)) b1 ();
    rv_mem_port_arbiter_if #(.XLEN(32), .ADDR_BITS(16)) b3 ();

    rv_mem_port_arbiter #(.XLEN(32), .ADDR_BITS(16), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst), .sync_reset(srst), .bus(b1));
    rv_mem_port_arbiter #(.XLEN(32), .ADDR_BITS(16), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(rst), .sync_reset(srst), .bus(b3));

    assign b1.ocd_read_enable = ocd_re;   assign b3.ocd_read_enable = ocd_re;
    assign b1.ocd_write_enable = ocd_we;  assign b3.ocd_write_enable = ocd_we;
    assign b1.ocd_rw_addr = ocd_addr;     assign b3.ocd_rw_addr = ocd_addr;
    assign b1.ocd_write_word = ocd_wd;    assign b3.ocd_write_word = ocd_wd;
    assign b1.code_read_enable = code_re; assign b3.code_read_enable = code_re;
    assign b1.code_read_addr = code_addr; assign b3.code_read_addr = code_addr;
    assign b1.data_read_enable = dre;     assign b3.data_read_enable = dre;
    assign b1.data_write_enable = dwe;    assign b3.data_write_enable = dwe;
    assign b1.data_size = dsize;          assign b3.data_size = dsize;
    assign b1.data_unsigned = duns;       assign b3.data_unsigned = duns;
    assign b1.data_rw_addr = daddr;       assign b3.data_rw_addr = daddr;
    assign b1.data_write_word = dwd;      assign b3.data_write_word = dwd;
    assign b1.mem_read_data = rdata;      assign b3.mem_read_data = rdata;

    logic        o_en [2];
    logic [1:0]  o_src [2];
    logic [31:0] o_word [2];
    logic        o_mis [2];
    logic [2:0]  o_g [2];
    logic [13:0] o_addr [2];
    logic        o_re [2];
    logic [3:0]  o_be [2];
    logic [31:0] o_wd [2];

    assign o_en[0] = b1.enable_out;      assign o_en[1] = b3.enable_out;
    assign o_src[0] = b1.source_out;     assign o_src[1] = b3.source_out;
    assign o_word[0] = b1.word_out;      assign o_word[1] = b3.word_out;
    assign o_mis[0] = b1.misaligned_err; assign o_mis[1] = b3.misaligned_err;
    assign o_g[0] = {b1.grant_data, b1.grant_code, b1.grant_ocd};
    assign o_g[1] = {b3.grant_data, b3.grant_code, b3.grant_ocd};
    assign o_addr[0] = b1.mem_addr;      assign o_addr[1] = b3.mem_addr;
    assign o_re[0] = b1.mem_read_enable; assign o_re[1] = b3.mem_read_enable;
    assign o_be[0] = b1.mem_write_en;    assign o_be[1] = b3.mem_write_en;
    assign o_wd[0] = b1.mem_write_data;  assign o_wd[1] = b3.mem_write_data;

    int lat [2] = '{1, 3};
    int n;
    int n_cmp = 0;
    int n_bad = 0;

    // Expected returns, indexed by the cycle they must appear in.
    bit         ev_v   [2][DEPTH];
    logic [1:0] ev_src [2][DEPTH];
    logic [1:0] ev_off [2][DEPTH];
    logic [1:0] ev_sz  [2][DEPTH];
    logic       ev_uns [2][DEPTH];
    bit         mis_exp [DEPTH];

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s L%0d cyc=%0d observed=%h expected=%h",
                   tag, lat[d], n, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(logic [1:0] s, logic [1:0] off,
                                        logic [1:0] sz, logic u,
                                        logic [31:0] rd);
        logic [31:0] v, m;
        int nb;
        if (s != 2'd2) return rd;
        v  = rd >> (8 * off);
        nb = 1 << sz;
        if (nb >= 4) return v;
        m = (32'd1 << (8 * nb)) - 32'd1;
        v = v & m;
        if (!u && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    task automatic clear_from(int k0);
        for (int k = k0; k < DEPTH; k++) begin
            mis_exp[k] = 1'b0;
            for (int d = 0; d < 2; d++) ev_v[d][k] = 1'b0;
        end
    endtask

    task automatic idle();
        ocd_re = 0; ocd_we = 0; code_re = 0; dre = 0; dwe = 0;
    endtask

    task automatic cyc();
        int g, off, nb;
        logic [13:0] ea;
        logic ere, emis;
        logic [3:0] ebe;
        logic [31:0] ewd;
        off  = int'(daddr[1:0]);
        nb   = 1 << dsize;
        emis = (dsize == 2'd3) || (off % nb != 0);
        ea = daddr[15:2]; ere = 0; ebe = 0; ewd = 0; g = 3;
        if (ocd_re || ocd_we) begin
            g = 0; ea = ocd_addr;
            if (ocd_we) begin ebe = 4'hF; ewd = ocd_wd; end
            else ere = 1;
        end else if (code_re) begin
            g = 1; ea = code_addr; ere = 1;
        end else if (dre || dwe) begin
            g = 2;
            if (!emis) begin
                if (dwe) begin
                    ebe = 4'(((1 << nb) - 1) << off);
                    for (int i = 0; i < 4; i++)
                        ewd[8*i+:8] = dwd[8*(i % nb)+:8];
                end else ere = 1;
            end
        end
        if (srst) begin ere = 0; ebe = 0; end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("grant", d, 64'(o_g[d]), (g == 3) ? 64'd0 : 64'(1 << g));
            chk("mem_addr", d, 64'(o_addr[d]), 64'(ea));
            chk("mem_re", d, 64'(o_re[d]), 64'(ere));
            chk("mem_be", d, 64'(o_be[d]), 64'(ebe));
            if (ebe != 0) chk("mem_wdata", d, 64'(o_wd[d]), 64'(ewd));
            chk("enable_out", d, 64'(o_en[d]), 64'(ev_v[d][n]));
            if (ev_v[d][n]) begin
                chk("source_out", d, 64'(o_src[d]), 64'(ev_src[d][n]));
                chk("word_out", d, 64'(o_word[d]),
                    64'(fmt(ev_src[d][n], ev_off[d][n], ev_sz[d][n],
                            ev_uns[d][n], rdata)));
            end
            chk("mis_err", d, 64'(o_mis[d]), 64'(mis_exp[n]));
        end
        @(posedge clk);
        if (srst) clear_from(n + 1);
        else mis_exp[n+1] = (g == 2) && emis;
        if (ere) begin
            for (int d = 0; d < 2; d++) begin
                ev_v[d][n+lat[d]]   = 1'b1;
                ev_src[d][n+lat[d]] = 2'(g);
                ev_off[d][n+lat[d]] = daddr[1:0];
                ev_sz[d][n+lat[d]]  = dsize;
                ev_uns[d][n+lat[d]] = duns;
            end
        end
        n++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_from(n);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_en", d, 64'(o_en[d]), 64'd0);
            chk("rst_src", d, 64'(o_src[d]), 64'd0);
            chk("rst_mis", d, 64'(o_mis[d]), 64'd0);
        end
        @(posedge clk);
        n++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1; srst = 0; idle();
        ocd_addr = 0; code_addr = 0; ocd_wd = 0; dwd = 0;
        dsize = 0; duns = 0; daddr = 0; rdata = 0;
        n = 0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("init_en", d, 64'(o_en[d]), 64'd0);
            chk("init_mis", d, 64'(o_mis[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 0;

        rdata = 32'hCAFE_0123;
        code_re = 1; code_addr = 14'h10;
        dre = 1; daddr = 16'h0080; dsize = 2; duns = 1;
        cyc();
        code_re = 0;
        cyc();
        idle(); cyc(); cyc(); cyc();

        dwe = 1; daddr = 16'h0103; dsize = 0; dwd = 32'h0000_00A5;
        cyc();
        idle();
        rdata = 32'hA500_0000;
        dre = 1; duns = 0; cyc();
        duns = 1; cyc();
        idle(); cyc(); cyc(); cyc(); cyc();

        dre = 1; daddr = 16'h0101; dsize = 1; duns = 0;
        cyc();
        idle(); cyc(); cyc();

        code_re = 1;
        for (int i = 1; i <= 3; i++) begin
            code_addr = 14'(i);
            rdata = 32'h1000_0000 + i;
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rdata = 32'h2000_0000 + i;
            cyc();
        end

        code_re = 1; code_addr = 14'h22; cyc();
        idle(); do_reset();
        cyc(); cyc(); cyc(); cyc();
        code_re = 1; code_addr = 14'h33; cyc();
        idle(); srst = 1; code_re = 1; cyc();
        srst = 0; idle(); cyc(); cyc(); cyc(); cyc();

        ocd_we = 1; ocd_re = 1; ocd_addr = 14'h0ABC; ocd_wd = 32'h1234_5678;
        code_re = 1; dre = 1; dwe = 1;
        cyc();
        idle(); cyc(); cyc(); cyc();

        for (int k = 0; k < 400; k++) begin
            ocd_re    = ($urandom_range(0, 9) == 0);
            ocd_we    = ($urandom_range(0, 11) == 0);
            ocd_addr  = 14'($urandom);
            ocd_wd    = $urandom;
            code_re   = ($urandom_range(0, 3) == 0);
            code_addr = 14'($urandom);
            dre       = ($urandom_range(0, 1) == 0);
            dwe       = ($urandom_range(0, 3) == 0);
            dsize     = 2'($urandom);
            duns      = 1'($urandom);
            daddr     = 16'($urandom);
            dwd       = $urandom;
            rdata     = $urandom;
            srst      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) begin
                srst = 0;
                do_reset();
            end else begin
                cyc();
            end
        end
        srst = 0; idle();
        for (int i = 0; i < 5; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
